// File: rtl/regbank_pkg.sv
// Shared encodings for the register-bank sequencer and its arbiter.
package regbank_pkg;

  typedef enum logic [1:0] {
    OpInc  = 2'b00,
    OpMove = 2'b01,
    OpLoad = 2'b10,
    OpRead = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StStrobe,
    StRelease,
    StFin
  } state_e;

  function automatic logic op_uses_src(op_e op);
    return (op == OpMove) || (op == OpRead);
  endfunction

  function automatic logic op_uses_dst(op_e op);
    return op != OpRead;
  endfunction

endpackage

// File: rtl/inc_reg16.sv
// 16-bit bank register: captures the bus, or increments, at the clock edge that releases its
// active-low strobe.
module inc_reg16 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        latch_ni,
  input  logic        inc_ni,
  input  logic [15:0] bus_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 16'h0000;
    end else if (!latch_ni) begin
      q_q <= bus_i;
    end else if (!inc_ni) begin
      q_q <= q_q + 16'h0001;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-served pointer moves only on an accepted grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&valid_i) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = valid_i;
      end
    end
    last_d = last_q;
    if (|(valid_i & gnt_o)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regbank_seq.sv
// Sequencer for a shared-bus register bank: arbitrates two requesters and emits registered,
// correctly ordered active-low oe/latch/inc strobes.
module regbank_seq
  import regbank_pkg::*;
#(
  parameter int unsigned NREGS = 4,
  parameter int unsigned IDXW  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_valid_i,
  input  logic [3:0]        req_op_i,
  input  logic [2*IDXW-1:0] req_src_i,
  input  logic [2*IDXW-1:0] req_dst_i,
  output logic [1:0]        req_ready_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [NREGS-1:0]  oe_o,
  output logic [NREGS-1:0]  latch_o,
  output logic [NREGS-1:0]  inc_o,
  output logic              ext_oe_o,
  output logic              ext_latch_o
);

  state_e           state_q, state_d;
  op_e              op_q, op_d, sel_op;
  logic [IDXW-1:0]  src_q, src_d, dst_q, dst_d, sel_src, sel_dst;
  logic             who_q, who_d, ill_q, ill_d, sel_who;
  logic             arb_en, accept, drv, stb;
  logic [NREGS-1:0] oe_q, oe_d, latch_q, latch_d, inc_q, inc_d;
  logic             ext_oe_q, ext_oe_d, ext_latch_q, ext_latch_d, err_q, err_d;
  logic [1:0]       done_q, done_d;

  function automatic logic cmd_illegal(op_e op, logic [IDXW-1:0] s, logic [IDXW-1:0] d);
    logic bad;
    bad = (op == OpMove) && (s == d);
    if (op_uses_src(op) && (32'(s) >= NREGS)) bad = 1'b1;
    if (op_uses_dst(op) && (32'(d) >= NREGS)) bad = 1'b1;
    return bad;
  endfunction

  // Grants are withheld while reset is asserted.
  assign arb_en = rst_ni && (state_q == StIdle);

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (arb_en),
    .valid_i (req_valid_i),
    .gnt_o   (req_ready_o)
  );

  assign accept  = |(req_valid_i & req_ready_o);
  assign sel_who = req_ready_o[1];
  assign sel_op  = op_e'(sel_who ? req_op_i[3:2] : req_op_i[1:0]);
  assign sel_src = sel_who ? req_src_i[2*IDXW-1:IDXW] : req_src_i[IDXW-1:0];
  assign sel_dst = sel_who ? req_dst_i[2*IDXW-1:IDXW] : req_dst_i[IDXW-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    who_d   = who_q;
    ill_d   = ill_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = sel_op;
          src_d = sel_src;
          dst_d = sel_dst;
          who_d = sel_who;
          ill_d = cmd_illegal(sel_op, sel_src, sel_dst);
          if (ill_d)                 state_d = StFin;
          else if (sel_op == OpInc)  state_d = StStrobe;
          else                       state_d = StDrive;
        end
      end
      StDrive:   state_d = StStrobe;
      StStrobe:  state_d = StRelease;
      StRelease: state_d = StFin;
      StFin:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    oe_d        = '1;
    latch_d     = '1;
    inc_d       = '1;
    done_d      = 2'b00;
    err_d       = 1'b0;
    drv         = (state_d == StDrive) || (state_d == StStrobe) || (state_d == StRelease);
    stb         = (state_d == StStrobe);
    ext_oe_d    = !(drv && (op_d == OpLoad));
    ext_latch_d = !(stb && (op_d == OpRead));
    for (int i = 0; i < int'(NREGS); i++) begin
      if (drv && op_uses_src(op_d) && (src_d == IDXW'(i))) oe_d[i] = 1'b0;
      if (stb && (op_d == OpInc) && (dst_d == IDXW'(i))) inc_d[i] = 1'b0;
      if (stb && ((op_d == OpMove) || (op_d == OpLoad)) && (dst_d == IDXW'(i))) begin
        latch_d[i] = 1'b0;
      end
    end
    if (state_d == StFin) begin
      done_d[who_d] = 1'b1;
      err_d         = ill_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= OpInc;
      src_q       <= '0;
      dst_q       <= '0;
      who_q       <= 1'b0;
      ill_q       <= 1'b0;
      oe_q        <= '1;
      latch_q     <= '1;
      inc_q       <= '1;
      ext_oe_q    <= 1'b1;
      ext_latch_q <= 1'b1;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      who_q       <= who_d;
      ill_q       <= ill_d;
      oe_q        <= oe_d;
      latch_q     <= latch_d;
      inc_q       <= inc_d;
      ext_oe_q    <= ext_oe_d;
      ext_latch_q <= ext_latch_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign oe_o        = oe_q;
  assign latch_o     = latch_q;
  assign inc_o       = inc_q;
  assign ext_oe_o    = ext_oe_q;
  assign ext_latch_o = ext_latch_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_regbank_seq.sv
// Scoreboard bench for regbank_seq driving four inc_reg16 registers on a shared bus.
module tb_regbank_seq;
  localparam int NR = 4;
  localparam int IW = 3;
  localparam int INC = 0, MOVE = 1, LOAD = 2, READ = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_ready, done;
  logic [3:0]      req_op;
  logic [2*IW-1:0] req_src, req_dst;
  logic            err, busy, ext_oe, ext_latch;
  logic [NR-1:0]   oe, latch, inc;
  logic [15:0]     q [NR];
  logic [15:0]     bus, ext_val, ext_cap;
  int              cyc = 0, checks = 0, errors = 0;

  typedef struct {
    int                   who;
    bit                   err;
    int                   lat;
    int                   acc;
    int                   nsrc;
    int                   nstb;
    int                   sid;
    int                   tid;
    logic [NR-1:0][15:0]  regs;
    logic [15:0]          ext;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: register contents, external sink and last-served requester.
  logic [NR-1:0][15:0] m_regs;
  logic [15:0]         m_ext;
  int                  m_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regbank_seq #(.NREGS(NR), .IDXW(IW)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_src_i   (req_src),
    .req_dst_i   (req_dst),
    .req_ready_o (req_ready),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .oe_o        (oe),
    .latch_o     (latch),
    .inc_o       (inc),
    .ext_oe_o    (ext_oe),
    .ext_latch_o (ext_latch)
  );

  for (genvar g = 0; g < NR; g++) begin : g_reg
    inc_reg16 u_reg (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .latch_ni (latch[g]),
      .inc_ni   (inc[g]),
      .bus_i    (bus),
      .q_o      (q[g])
    );
  end

  always_comb begin
    bus = 16'h0bad;
    if (!ext_oe) bus = ext_val;
    for (int i = 0; i < NR; i++) if (!oe[i]) bus = q[i];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ext_cap <= 16'h0000;
    else if (!ext_latch) ext_cap <= bus;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply a command's architectural effect and queue the response it must produce.
  task automatic predict(input int r, input int op, input int s, input int d, input int acc);
    exp_t e;
    bit   ill;
    ill = (op == MOVE && s == d) || (op != READ && d >= NR) || ((op == MOVE || op == READ) && s >= NR);
    e.who = r; e.err = ill; e.acc = acc;
    e.lat = 0; e.nsrc = 0; e.nstb = 0; e.sid = -1; e.tid = -1;
    if (!ill) begin
      e.lat = 3; e.nsrc = 3; e.nstb = 1;
      case (op)
        INC:  begin m_regs[d] = m_regs[d] + 16'd1; e.lat = 2; e.nsrc = 0; e.tid = 8 + d; end
        MOVE: begin m_regs[d] = m_regs[s]; e.sid = s; e.tid = d; end
        LOAD: begin m_regs[d] = ext_val; e.sid = 16; e.tid = d; end
        default: begin m_ext = m_regs[s]; e.sid = s; e.tid = 16; end
      endcase
    end
    e.regs = m_regs;
    e.ext  = m_ext;
    exp_q.push_back(e);
    m_last = r;
  endtask

  task automatic issue(input int r, input int op, input int s, input int d);
    int n = 0;
    bit got = 0;
    req_op[2*r +: 2]   = 2'(op);
    req_src[IW*r +: IW] = IW'(s);
    req_dst[IW*r +: IW] = IW'(d);
    req_valid[r] = 1'b1;
    while (!got && n < 60) begin
      #1;
      if (req_ready[r]) got = 1;
      else begin n++; @(negedge clk); end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: requester %0d got no grant, expected one", r);
      req_valid[r] = 1'b0;
      return;
    end
    predict(r, op, s, d, cyc + 1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, expected idle", busy, exp_q.size());
    end
  endtask

  task automatic arb_both(input int ngr);
    int g = 0, n = 0, pw;
    req_op = 4'b0000;
    req_src = '0;
    req_dst[IW-1:0]   = IW'(0);
    req_dst[2*IW-1:IW] = IW'(3);
    req_valid = 2'b11;
    while (g < ngr && n < 200) begin
      #1;
      if (|(req_valid & req_ready)) begin
        pw = (m_last == 1) ? 0 : 1;
        chk("grant_order", 64'(req_ready), (pw == 1) ? 64'd2 : 64'd1);
        predict(pw, INC, 0, (pw == 1) ? 3 : 0, cyc + 1);
        g++;
        @(posedge clk);
        #1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    req_valid = 2'b00;
    if (g < ngr) begin
      checks++; errors++;
      $display("FAIL arb_timeout: got %0d grants, expected %0d", g, ngr);
    end
  endtask

  // Monitor: per-cycle bus invariants, strobe accounting, and scoreboard pops on done.
  initial begin
    int   nsrc, nstb, sid, tid;
    exp_t e;
    nsrc = 0; nstb = 0; sid = -1; tid = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nsrc = 0; nstb = 0; sid = -1; tid = -1;
      end else begin
        checks++;
        if ($countones({~oe, ~ext_oe}) > 1 || $countones({~latch, ~inc, ~ext_latch}) > 1 ||
            (|(~oe & ~latch))) begin
          errors++;
          $display("FAIL invariant: oe=%b ext_oe=%b latch=%b inc=%b ext_latch=%b, expected legal",
                   oe, ext_oe, latch, inc, ext_latch);
        end
        if (!ext_oe) begin nsrc++; sid = 16; end
        if (!ext_latch) begin nstb++; tid = 16; end
        for (int i = 0; i < NR; i++) begin
          if (!oe[i]) begin nsrc++; sid = i; end
          if (!latch[i]) begin nstb++; tid = i; end
          if (!inc[i]) begin nstb++; tid = 8 + i; end
        end
        if (done != 2'b00 || err) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: done=%b err=%b, expected none", done, err);
          end else begin
            e = exp_q.pop_front();
            chk("done_who", 64'(done), (e.who == 1) ? 64'd2 : 64'd1);
            chk("err", 64'(err), 64'(e.err));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("src_cycles", 64'(nsrc), 64'(e.nsrc));
            chk("strobe_cycles", 64'(nstb), 64'(e.nstb));
            chk("src_id", 64'(sid), 64'(e.sid));
            chk("strobe_id", 64'(tid), 64'(e.tid));
            chk("regs", 64'({q[3], q[2], q[1], q[0]}), 64'(e.regs));
            chk("ext_capture", 64'(ext_cap), 64'(e.ext));
          end
          nsrc = 0; nstb = 0; sid = -1; tid = -1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, r, op, s, d;
    rst_n = 1'b0; req_valid = 2'b11; req_op = '0; req_src = '0; req_dst = '0; ext_val = '0;
    m_regs = '0; m_ext = '0; m_last = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_outputs", 64'({oe, latch, inc, ext_oe, ext_latch, done, err, busy}),
        64'({4'hf, 4'hf, 4'hf, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}));
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    ext_val = 16'hfefa;
    issue(0, LOAD, 0, 2);
    wait_idle();
    chk("r2_load", 64'(q[2]), 64'hfefa);
    for (int i = 0; i < 10; i++) issue(0, INC, 0, 2);
    wait_idle();
    chk("r2_inc", 64'(q[2]), 64'hff04);

    ext_val = 16'h1234;
    issue(0, MOVE, 2, 1);
    issue(1, READ, 1, 0);
    wait_idle();
    chk("r1_move", 64'(q[1]), 64'hff04);
    chk("read_ext", 64'(ext_cap), 64'hff04);

    arb_both(4);
    wait_idle();
    chk("arb_r0", 64'(q[0]), 64'd2);
    chk("arb_r3", 64'(q[3]), 64'd2);

    issue(0, MOVE, 1, 1);
    issue(1, MOVE, 5, 2);
    issue(0, INC, 0, 6);
    wait_idle();

    // Reset in the middle of a MOVE's strobe cycle.
    issue(0, MOVE, 2, 1);
    n = 0;
    while (latch == 4'hf && n < 10) begin @(negedge clk); n++; end
    chk("move_strobe", 64'(latch), 64'hd);
    #2 rst_n = 1'b0;
    exp_q.delete();
    m_regs = '0; m_ext = '0; m_last = 1;
    #1;
    chk("async_strobes", 64'({oe, latch, inc, ext_oe, ext_latch}), 64'h3fff);
    chk("async_status", 64'({busy, done, err, req_ready}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    issue(0, INC, 0, 0);
    wait_idle();
    chk("post_reset_inc", 64'(q[0]), 64'd1);

    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 1);
      op = $urandom_range(0, 3);
      s  = $urandom_range(0, 3);
      d  = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        if (op == READ) s = $urandom_range(4, 7);
        else d = $urandom_range(4, 7);
      end
      if (op == LOAD) begin
        wait_idle();
        ext_val = 16'($urandom);
      end
      issue(r, op, s, d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
